// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM that steps the PC through
// IF/ID/EX/MEM/WB and drives the fetch, decode and write-back strobes.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [5:0]  HALT_OP      = 6'b111111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [25:0]        jaddr,
  input  logic signed [31:0] imm,
  input  logic               zero,
  input  logic [31:0]        pc_cur,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               ir_we,
  output logic               pc_we,
  output logic [31:0]        pc_next,
  output logic [31:0]        pc_reset_data,
  output logic               reg_we,
  output logic [2:0]         state,
  output logic               halted
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op_q;

  // Sequential fetch: wraps modulo 2^32 through natural 32-bit truncation.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Pseudo-direct jump: keep the top nibble of the current PC.
  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                              input logic [25:0] ja);
    return {pc[31:28], ja, 2'b00};
  endfunction

  // Branch offset is a signed word count; scale to bytes and add modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic signed [31:0] off);
    logic signed [31:0] off_bytes;
    off_bytes = off <<< 2;
    return pc + $unsigned(off_bytes);
  endfunction

  assign pc_reset_data = RESET_VECTOR;
  assign state         = state_q;

  // State register and opcode latch; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= opcode;
    end
  end

  // Next-state decode; undefined encodings fall back to IF.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:   state_d = mem_ready ? S_ID : S_IF;
      S_ID: begin
        if (opcode == OP_J)         state_d = S_IF;
        else if (opcode == HALT_OP) state_d = S_HALT;
        else                        state_d = S_EX;
      end
      S_EX: begin
        if (op_q == OP_RTYPE)                     state_d = S_WB;
        else if (op_q == OP_LW || op_q == OP_SW)  state_d = S_MEM;
        else                                      state_d = S_IF;
      end
      S_MEM: begin
        if (!mem_ready)          state_d = S_MEM;
        else if (op_q == OP_LW)  state_d = S_WB;
        else                     state_d = S_IF;
      end
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Strobe and PC-source decode; everything is held low while reset is high.
  always_comb begin
    mem_req = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    reg_we  = 1'b0;
    halted  = 1'b0;
    pc_next = pc_cur;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            pc_next = pc_inc(pc_cur);
          end
        end
        S_ID: begin
          if (opcode == OP_J) begin
            pc_we   = 1'b1;
            pc_next = jump_target(pc_cur, jaddr);
          end
        end
        S_EX: begin
          if (op_q == OP_BEQ && zero) begin
            pc_we   = 1'b1;
            pc_next = branch_target(pc_cur, imm);
          end
        end
        S_MEM:  mem_req = 1'b1;
        S_WB:   reg_we  = 1'b1;
        S_HALT: halted  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: walks each instruction class through
// the FSM and checks state, strobes and pc_next at every step.
module tb_pc_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic [5:0]         opcode;
  logic [25:0]        jaddr;
  logic signed [31:0] imm;
  logic               zero;
  logic [31:0]        pc_cur;
  logic               mem_ready;
  logic               mem_req, ir_we, pc_we, reg_we, halted;
  logic [31:0]        pc_next, pc_reset_data;
  logic [2:0]         state;

  int n_vec  = 0;
  int n_miss = 0;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .jaddr        (jaddr),
    .imm          (imm),
    .zero         (zero),
    .pc_cur       (pc_cur),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_next      (pc_next),
    .pc_reset_data(pc_reset_data),
    .reg_we       (reg_we),
    .state        (state),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move just past the next rising edge, leaving time to drive and settle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Packed strobes {mem_req, ir_we, pc_we, reg_we, halted}.
  function automatic logic [31:0] strobes();
    return {27'd0, mem_req, ir_we, pc_we, reg_we, halted};
  endfunction

  // Fetch with memory ready: checks IF outputs, then advances into ID.
  task automatic fetch(input string tag, input logic [5:0] op, input logic [31:0] pc);
    opcode = op; pc_cur = pc; mem_ready = 1'b1;
    #1;
    chk({tag, "_if_state"}, state, 32'd0);
    chk({tag, "_if_strb"},  strobes(), 32'b11100);
    chk({tag, "_if_pcnxt"}, pc_next, pc + 32'd4);
    tick();
    mem_ready = 1'b0;
    pc_cur    = pc + 32'd4;
    #1;
    chk({tag, "_id_state"}, state, 32'd1);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; jaddr = 26'd0; imm = 32'sd0;
    zero = 1'b0; pc_cur = 32'h0000_3000; mem_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_state", state, 32'd0);
    chk("rst_strb",  strobes(), 32'd0);
    chk("rst_vec",   pc_reset_data, 32'h0000_3000);
    @(posedge clk); tick();
    reset = 1'b0;
    #1;
    chk("post_rst_state", state, 32'd0);
    chk("post_rst_strb",  strobes(), 32'b10000);
    chk("post_rst_pcnxt", pc_next, 32'h0000_3000);
    tick();
    #1;
    chk("if_wait_state", state, 32'd0);
    chk("if_wait_strb",  strobes(), 32'b10000);

    // R-type: IF, ID, EX, WB, IF
    fetch("rt", 6'b000000, 32'h0000_3000);
    chk("rt_id_strb", strobes(), 32'd0);
    chk("rt_id_pcnxt", pc_next, 32'h0000_3004);
    mem_ready = 1'b1;
    tick(); #1;
    chk("rt_ex_state", state, 32'd2);
    chk("rt_ex_strb",  strobes(), 32'd0);
    mem_ready = 1'b0;
    tick(); #1;
    chk("rt_wb_state", state, 32'd4);
    chk("rt_wb_strb",  strobes(), 32'b00010);
    tick(); #1;
    chk("rt_back_state", state, 32'd0);
    chk("rt_back_strb",  strobes(), 32'b10000);

    // LW with three wait cycles in MEM
    fetch("lw", 6'b100011, 32'h0000_3004);
    tick(); #1;
    chk("lw_ex_state", state, 32'd2);
    tick(); #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_mem_wait_state", state, 32'd3);
      chk("lw_mem_wait_strb",  strobes(), 32'b10000);
      tick(); #1;
    end
    mem_ready = 1'b1; #1;
    chk("lw_mem_done_state", state, 32'd3);
    chk("lw_mem_done_strb",  strobes(), 32'b10000);
    tick(); mem_ready = 1'b0; #1;
    chk("lw_wb_state", state, 32'd4);
    chk("lw_wb_strb",  strobes(), 32'b00010);
    tick(); #1;
    chk("lw_back_state", state, 32'd0);

    // SW with the same memory stimulus
    fetch("sw", 6'b101011, 32'h0000_3008);
    tick(); tick(); #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw_mem_wait_state", state, 32'd3);
      chk("sw_mem_wait_strb",  strobes(), 32'b10000);
      tick(); #1;
    end
    mem_ready = 1'b1; #1;
    chk("sw_mem_done_strb", strobes(), 32'b10000);
    tick(); mem_ready = 1'b0; #1;
    chk("sw_back_state", state, 32'd0);
    chk("sw_back_strb",  strobes(), 32'b10000);

    // BEQ taken: 0x3004 + (-2 << 2) = 0x2FFC
    fetch("beq1", 6'b000100, 32'h0000_3000);
    imm = 32'shFFFF_FFFE; zero = 1'b1;
    tick(); #1;
    chk("beq1_ex_state", state, 32'd2);
    chk("beq1_ex_strb",  strobes(), 32'b00100);
    chk("beq1_ex_pcnxt", pc_next, 32'h0000_2FFC);
    tick(); #1;
    chk("beq1_back_state", state, 32'd0);

    // BEQ not taken
    fetch("beq0", 6'b000100, 32'h0000_3000);
    zero = 1'b0;
    tick(); #1;
    chk("beq0_ex_state", state, 32'd2);
    chk("beq0_ex_strb",  strobes(), 32'd0);
    chk("beq0_ex_pcnxt", pc_next, 32'h0000_3004);
    tick(); #1;
    chk("beq0_back_state", state, 32'd0);

    // J: {0x0, 0x0000C10, 00} = 0x3040
    jaddr = 26'h000_0C10;
    fetch("j", 6'b000010, 32'h0000_3000);
    chk("j_id_strb",  strobes(), 32'b00100);
    chk("j_id_pcnxt", pc_next, 32'h0000_3040);
    tick(); #1;
    chk("j_back_state", state, 32'd0);

    // PC wrap, then an unlisted opcode (ADDI) passes through EX silently
    fetch("wrap", 6'b001000, 32'hFFFF_FFFC);
    chk("wrap_id_pcnxt", pc_next, 32'h0000_0000);
    mem_ready = 1'b1;
    tick(); #1;
    chk("addi_ex_state", state, 32'd2);
    chk("addi_ex_strb",  strobes(), 32'd0);
    mem_ready = 1'b0;
    tick(); #1;
    chk("addi_back_state", state, 32'd0);

    // HALT opcode: absorbing
    fetch("halt", 6'b111111, 32'h0000_3010);
    tick(); #1;
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0]; #1;
      chk("halt_state", state, 32'd5);
      chk("halt_strb",  strobes(), 32'b00001);
      tick();
    end

    // Asynchronous reset out of HALT
    reset = 1'b1; #1;
    chk("halt_rst_state", state, 32'd0);
    chk("halt_rst_strb",  strobes(), 32'd0);
    tick(); reset = 1'b0; mem_ready = 1'b0; #1;
    chk("halt_rel_state", state, 32'd0);
    chk("halt_rel_strb",  strobes(), 32'b10000);

    // Reset pulse in the middle of an IF wait
    tick(); #1;
    chk("ifw_state", state, 32'd0);
    reset = 1'b1; #1;
    chk("ifw_rst_state", state, 32'd0);
    chk("ifw_rst_strb",  strobes(), 32'd0);
    tick(); reset = 1'b0; #1;
    chk("ifw_rel_state", state, 32'd0);
    chk("ifw_rel_strb",  strobes(), 32'b10000);

    // Reset pulse in the middle of a MEM wait abandons the access
    fetch("lwr", 6'b100011, 32'h0000_3000);
    tick(); tick(); #1;
    chk("lwr_mem_state", state, 32'd3);
    #3;
    reset = 1'b1; #1;
    chk("lwr_rst_state", state, 32'd0);
    chk("lwr_rst_strb",  strobes(), 32'd0);
    tick(); reset = 1'b0; #1;
    chk("lwr_rel_state", state, 32'd0);
    chk("lwr_rel_strb",  strobes(), 32'b10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
